lanzador_bombas: RTL and testbench

- Consumer side of the random-position generator. Requests raw pseudo-random words one at a time with a one-cycle take pulse, range-reduces each word to an alien column and rejects columns with no live alien.
- Launches a single alien bomb from the chosen column and steps it down the screen on frame ticks.
- Reports whether the bomb ended by collision or by leaving the playfield.
- Sits between the random generator, the alien-grid block (column occupancy) and the collision/drawing logic.

---
 rtl/lanzador_bombas.sv | 145 ++++++++++++++
 tb/tb_lanzador_bombas.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lanzador_bombas.sv
// Alien bomb launcher: draws random columns until a live one is found, then drops
// a single bomb on frame ticks and reports whether it ended by impact or by leaving.
module lanzador_bombas #(
  parameter int BITS_RESULTADO = 11,
  parameter int NUM_COLUMNAS   = 8,
  parameter int ANCHO_COLUMNA  = 64,
  parameter int X_ORIGEN       = 64,
  parameter int Y_INICIO       = 100,
  parameter int Y_LIMITE       = 470,
  parameter int PASO_Y         = 4,
  parameter int MAX_INTENTOS   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tick_cuadro,
  input  logic                      habilitar,
  input  logic [BITS_RESULTADO-1:0] rand_in,
  output logic                      rand_tomar,
  input  logic [NUM_COLUMNAS-1:0]   columnas_vivas,
  input  logic                      impacto,
  output logic                      bomba_activa,
  output logic [BITS_RESULTADO-1:0] bomba_x,
  output logic [BITS_RESULTADO-1:0] bomba_y,
  output logic                      evento_fin,
  output logic                      fin_por_impacto
);

  localparam int BITS_COL = $clog2(NUM_COLUMNAS);
  localparam int BITS_INT = $clog2(MAX_INTENTOS + 1);

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] ELEGIR = 2'd1;
  localparam logic [1:0] CAER   = 2'd2;
  localparam logic [1:0] FIN    = 2'd3;

  localparam logic [BITS_RESULTADO-1:0] X_CENTRO0  = BITS_RESULTADO'(X_ORIGEN + ANCHO_COLUMNA / 2);
  localparam logic [BITS_RESULTADO-1:0] ANCHO_W    = BITS_RESULTADO'(ANCHO_COLUMNA);
  localparam logic [BITS_RESULTADO-1:0] Y_INICIO_W = BITS_RESULTADO'(Y_INICIO);
  localparam logic [BITS_RESULTADO:0]   PASO_W     = (BITS_RESULTADO + 1)'(PASO_Y);
  localparam logic [BITS_RESULTADO:0]   LIMITE_W   = (BITS_RESULTADO + 1)'(Y_LIMITE);
  localparam logic [BITS_INT-1:0]       ULTIMO_INT = BITS_INT'(MAX_INTENTOS - 1);

  logic [1:0]                estado_r, estado_sig_s;
  logic [BITS_INT-1:0]       intentos_r, intentos_sig_s;
  logic [BITS_RESULTADO-1:0] x_r, x_sig_s;
  logic [BITS_RESULTADO-1:0] y_r, y_sig_s;
  logic                      fin_imp_r, fin_imp_sig_s;
  logic                      tomar_r, tomar_sig_s;
  logic                      activa_r, evento_r;
  logic [BITS_COL-1:0]       col_s;
  logic [BITS_RESULTADO-1:0] col_ext_s;
  logic [BITS_RESULTADO-1:0] x_col_s;
  logic [BITS_RESULTADO:0]   y_prox_s;

  assign col_s     = rand_in[BITS_COL-1:0];
  assign col_ext_s = {{(BITS_RESULTADO - BITS_COL){1'b0}}, col_s};
  assign x_col_s   = X_CENTRO0 + col_ext_s * ANCHO_W;
  // One extra bit so a bomb near the bottom cannot wrap back to the top
  assign y_prox_s  = {1'b0, y_r} + PASO_W;

  // Next-state and datapath decisions; rand_tomar is predicted one cycle ahead so it can be registered
  always_comb begin
    estado_sig_s   = estado_r;
    intentos_sig_s = intentos_r;
    x_sig_s        = x_r;
    y_sig_s        = y_r;
    fin_imp_sig_s  = fin_imp_r;
    tomar_sig_s    = 1'b0;
    case (estado_r)
      REPOSO: begin
        if (habilitar && tick_cuadro) begin
          estado_sig_s   = ELEGIR;
          intentos_sig_s = {BITS_INT{1'b0}};
          tomar_sig_s    = |columnas_vivas;
        end else begin
          estado_sig_s = REPOSO;
        end
      end
      ELEGIR: begin
        if (!tomar_r || !habilitar || (columnas_vivas == {NUM_COLUMNAS{1'b0}})) begin
          estado_sig_s = REPOSO;
        end else if (columnas_vivas[col_s]) begin
          estado_sig_s = CAER;
          x_sig_s      = x_col_s;
          y_sig_s      = Y_INICIO_W;
        end else if (intentos_r == ULTIMO_INT) begin
          estado_sig_s = REPOSO;
        end else begin
          intentos_sig_s = intentos_r + {{(BITS_INT - 1){1'b0}}, 1'b1};
          tomar_sig_s    = 1'b1;
        end
      end
      CAER: begin
        if (impacto) begin
          estado_sig_s  = FIN;
          fin_imp_sig_s = 1'b1;
        end else if (tick_cuadro && (y_prox_s > LIMITE_W)) begin
          estado_sig_s  = FIN;
          fin_imp_sig_s = 1'b0;
        end else if (tick_cuadro) begin
          y_sig_s = y_prox_s[BITS_RESULTADO-1:0];
        end else begin
          estado_sig_s = CAER;
        end
      end
      FIN: begin
        estado_sig_s = REPOSO;
      end
      default: begin
        estado_sig_s = REPOSO;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_r   <= REPOSO;
      intentos_r <= {BITS_INT{1'b0}};
      x_r        <= {BITS_RESULTADO{1'b0}};
      y_r        <= {BITS_RESULTADO{1'b0}};
      fin_imp_r  <= 1'b0;
      tomar_r    <= 1'b0;
      activa_r   <= 1'b0;
      evento_r   <= 1'b0;
    end else begin
      estado_r   <= estado_sig_s;
      intentos_r <= intentos_sig_s;
      x_r        <= x_sig_s;
      y_r        <= y_sig_s;
      fin_imp_r  <= fin_imp_sig_s;
      tomar_r    <= tomar_sig_s;
      activa_r   <= (estado_sig_s == CAER);
      evento_r   <= (estado_sig_s == FIN);
    end
  end

  assign rand_tomar      = tomar_r;
  assign bomba_activa    = activa_r;
  assign bomba_x         = x_r;
  assign bomba_y         = y_r;
  assign evento_fin      = evento_r;
  assign fin_por_impacto = fin_imp_r;

endmodule

// File: tb/tb_lanzador_bombas.sv
// Self-checking bench for lanzador_bombas: directed scenarios plus randomized launches
// and flights, compared against a transaction-level model of draws and bomb motion.
module tb_lanzador_bombas;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick_cuadro;
  logic        habilitar;
  logic [10:0] rand_in;
  logic        rand_tomar;
  logic [7:0]  columnas_vivas;
  logic        impacto;
  logic        bomba_activa;
  logic [10:0] bomba_x;
  logic [10:0] bomba_y;
  logic        evento_fin;
  logic        fin_por_impacto;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] draws[$];
  int          idx;
  logic        tomar_visto;

  always #5 clk = ~clk;

  lanzador_bombas dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tick_cuadro     (tick_cuadro),
    .habilitar       (habilitar),
    .rand_in         (rand_in),
    .rand_tomar      (rand_tomar),
    .columnas_vivas  (columnas_vivas),
    .impacto         (impacto),
    .bomba_activa    (bomba_activa),
    .bomba_x         (bomba_x),
    .bomba_y         (bomba_y),
    .evento_fin      (evento_fin),
    .fin_por_impacto (fin_por_impacto)
  );

  task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic poner_rand();
    rand_in = (idx < draws.size()) ? draws[idx] : 11'h7FF;
  endtask

  // Advance one clock; a word is consumed at an edge when rand_tomar was high before it.
  task automatic ciclo();
    @(posedge clk);
    #1;
    if (tomar_visto) idx++;
    poner_rand();
    tomar_visto = rand_tomar;
  endtask

  task automatic chequear_ceros(input string tag);
    chequear({tag, "_tomar"},  32'(rand_tomar), 32'd0);
    chequear({tag, "_activa"}, 32'(bomba_activa), 32'd0);
    chequear({tag, "_x"},      32'(bomba_x), 32'd0);
    chequear({tag, "_y"},      32'(bomba_y), 32'd0);
    chequear({tag, "_fin"},    32'(evento_fin), 32'd0);
    chequear({tag, "_causa"},  32'(fin_por_impacto), 32'd0);
  endtask

  // Tick once with habilitar=1 using the current draws queue; predicts pulses and launch.
  task automatic lanzar(input logic [7:0] mask, output bit lanzo, output int x_exp);
    int k;
    int pulsos;
    logic [10:0] w;
    k = -1;
    for (int i = 0; i < draws.size() && i < 4; i++) begin
      w = draws[i];
      if (k < 0 && mask[w[2:0]]) k = i;
    end
    lanzo  = (k >= 0);
    pulsos = (mask == 8'd0) ? 0 : (lanzo ? k + 1 : 4);
    x_exp  = 0;
    if (lanzo) begin
      w     = draws[k];
      x_exp = 64 + 64 * int'(w[2:0]) + 32;
    end
    idx = 0;
    poner_rand();
    columnas_vivas = mask;
    habilitar      = 1'b1;
    tick_cuadro    = 1'b1;
    impacto        = 1'b0;
    ciclo();
    tick_cuadro = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chequear("sel_tomar",  32'(rand_tomar), 32'(c <= pulsos));
      chequear("sel_activa", 32'(bomba_activa), 32'(lanzo && c >= k + 2));
      chequear("sel_fin",    32'(evento_fin), 32'd0);
      if (c < 6) ciclo();
    end
    chequear("sel_consumidos", 32'(idx), 32'(pulsos));
    if (lanzo) begin
      chequear("sel_x", 32'(bomba_x), 32'(x_exp));
      chequear("sel_y", 32'(bomba_y), 32'd100);
    end
  endtask

  // Fly the bomb to its end; imp_at forces impacto together with a tick on that cycle.
  task automatic vuelo(input int x_exp, input int tick_pct, input int imp_pct,
                       input int imp_at, input bit alborotar);
    int y;
    int n;
    bit fin;
    bit causa;
    y = 100;
    n = 0;
    fin = 1'b0;
    causa = 1'b0;
    while (!fin && n < 400) begin
      n++;
      tick_cuadro = ($urandom_range(99) < tick_pct);
      impacto     = ($urandom_range(99) < imp_pct);
      if (imp_at == n) begin
        tick_cuadro = 1'b1;
        impacto     = 1'b1;
      end
      if (alborotar) begin
        habilitar      = 1'($urandom_range(1));
        columnas_vivas = 8'($urandom);
      end
      ciclo();
      if (impacto) begin
        fin = 1'b1;
        causa = 1'b1;
      end else if (tick_cuadro) begin
        if (y + 4 > 470) begin
          fin = 1'b1;
          causa = 1'b0;
        end else begin
          y += 4;
        end
      end
      chequear("vuelo_activa", 32'(bomba_activa), 32'(!fin));
      chequear("vuelo_fin",    32'(evento_fin), 32'(fin));
      chequear("vuelo_y",      32'(bomba_y), 32'(y));
      chequear("vuelo_x",      32'(bomba_x), 32'(x_exp));
      chequear("vuelo_tomar",  32'(rand_tomar), 32'd0);
      if (fin) chequear("vuelo_causa", 32'(fin_por_impacto), 32'(causa));
    end
    if (!fin) chequear("vuelo_timeout", 32'd0, 32'd1);
    tick_cuadro    = 1'b1;
    habilitar      = 1'b1;
    impacto        = 1'b0;
    columnas_vivas = 8'hFF;
    ciclo();
    tick_cuadro = 1'b0;
    chequear("post_activa", 32'(bomba_activa), 32'd0);
    chequear("post_fin",    32'(evento_fin), 32'd0);
    chequear("post_y",      32'(bomba_y), 32'(y));
    chequear("post_causa",  32'(fin_por_impacto), 32'(causa));
    ciclo();
    chequear("post_tomar",  32'(rand_tomar), 32'd0);
    chequear("post_activa2", 32'(bomba_activa), 32'd0);
  endtask

  // Assert reset between edges and check outputs clear before any clock edge.
  task automatic reset_async(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    chequear_ceros(tag);
    tomar_visto = 1'b0;
    habilitar   = 1'b1;
    tick_cuadro = 1'b0;
    impacto     = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ciclo();
    ciclo();
    chequear({tag, "_sin_lanz_tomar"},  32'(rand_tomar), 32'd0);
    chequear({tag, "_sin_lanz_activa"}, 32'(bomba_activa), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lanzo;
    int x;
    logic [7:0] mask;
    reset_n        = 1'b0;
    tick_cuadro    = 1'b0;
    habilitar      = 1'b0;
    impacto        = 1'b0;
    columnas_vivas = 8'd0;
    idx            = 0;
    tomar_visto    = 1'b0;
    poner_rand();
    repeat (3) @(posedge clk);
    #1;
    chequear_ceros("reset");
    reset_n = 1'b1;
    ciclo();

    // Immediate hit on column 3, then fall off the bottom after 93 ticks
    draws = '{11'd3};
    lanzar(8'hFF, lanzo, x);
    chequear("dir1_lanzo", 32'(lanzo), 32'd1);
    vuelo(288, 100, 0, 0, 1'b0);

    // Two rejects before column 4, then impact at y=200 together with a tick
    draws = '{11'd0, 11'd1, 11'd4};
    lanzar(8'h10, lanzo, x);
    vuelo(352, 100, 0, 26, 1'b0);

    // Exhausted attempts, then no live columns at all
    draws = '{11'd3, 11'd3, 11'd3, 11'd3};
    lanzar(8'h01, lanzo, x);
    draws = '{};
    lanzar(8'h00, lanzo, x);

    // Reset in the middle of selection, then in the middle of a flight
    draws = '{11'd3, 11'd3, 11'd3, 11'd3};
    idx = 0;
    poner_rand();
    columnas_vivas = 8'h01;
    habilitar      = 1'b1;
    tick_cuadro    = 1'b1;
    ciclo();
    tick_cuadro = 1'b0;
    chequear("mid_elegir_tomar", 32'(rand_tomar), 32'd1);
    reset_async("rst_elegir");

    draws = '{11'd5};
    lanzar(8'hFF, lanzo, x);
    tick_cuadro = 1'b1;
    ciclo();
    ciclo();
    tick_cuadro = 1'b0;
    chequear("mid_vuelo_y", 32'(bomba_y), 32'd108);
    reset_async("rst_vuelo");

    for (int it = 0; it < 20; it++) begin
      mask = 8'($urandom);
      if ($urandom_range(7) == 0) mask = 8'd0;
      draws = '{};
      for (int j = 0; j < 4; j++) draws.push_back(11'($urandom));
      lanzar(mask, lanzo, x);
      if (lanzo) vuelo(x, 60, 3, 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
